// File: rtl/cipher_packer_if.sv
// Byte-in / word-out bus for cipher_packer; the flush wire only exists when PACK_FLUSH_EN is defined.
interface cipher_packer_if;
  logic [7:0]  din;
  logic        din_v;
`ifdef PACK_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] dout;
  logic [2:0]  dout_bytes;
  logic        dout_v;
  logic        dout_rdy;

`ifdef PACK_FLUSH_EN
  modport master (output din, din_v, flush, dout_rdy, input dout, dout_bytes, dout_v);
  modport slave  (input din, din_v, flush, dout_rdy, output dout, dout_bytes, dout_v);
`else
  modport master (output din, din_v, dout_rdy, input dout, dout_bytes, dout_v);
  modport slave  (input din, din_v, dout_rdy, output dout, dout_bytes, dout_v);
`endif
endinterface

// File: rtl/cipher_packer.sv
// Packs encrypted bytes into little-endian 32-bit words and queues them in a small FIFO.
// Optional macro PACK_FLUSH_EN adds a flush input that emits a partial word.
module cipher_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  cipher_packer_if.slave                bus,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [1:0]    cnt_q;
  logic [23:0]   asm_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem_word  [FIFO_DEPTH];
  logic [2:0]    mem_bytes [FIFO_DEPTH];

  logic [31:0] word_next;
  logic [2:0]  cnt_after;
  logic        push_req;
  logic        pop;
  logic        full;
  logic        do_push;
  logic        ovf_set;

  // Fold any same-edge byte into the pending word before deciding whether to push.
  always_comb begin
    word_next = {8'h00, asm_q};
    cnt_after = {1'b0, cnt_q};
    if (bus.din_v) begin
      word_next[{cnt_q, 3'b000} +: 8] = bus.din;
      cnt_after = cnt_after + 3'd1;
    end
    push_req = (cnt_after == 3'd4);
`ifdef PACK_FLUSH_EN
    if (bus.flush && (cnt_after != 3'd0))
      push_req = 1'b1;
`endif
  end

  assign pop     = (level != '0) && bus.dout_rdy;
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign do_push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_req) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_after[1:0];
        asm_q <= word_next[23:0];
      end
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)
        level <= level + 1'b1;
      else if (!do_push && pop)
        level <= level - 1'b1;
      if (ovf_set)
        ovf <= 1'b1;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_word[wr_ptr]  <= word_next;
      mem_bytes[wr_ptr] <= cnt_after;
    end
  end

  assign bus.dout_v     = (level != '0);
  assign bus.dout       = bus.dout_v ? mem_word[rd_ptr]  : 32'h0;
  assign bus.dout_bytes = bus.dout_v ? mem_bytes[rd_ptr] : 3'd0;
endmodule

// File: tb/tb_cipher_packer.sv
// Directed self-checking bench for cipher_packer with hand-computed expected words.
module tb_cipher_packer;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic       ovf;
  int         test_count = 0;
  int         fail_count = 0;

  cipher_packer_if bus ();

  cipher_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .level (level),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic rdy, input logic fl);
    bus.din      = d;
    bus.din_v    = v;
    bus.dout_rdy = rdy;
`ifdef PACK_FLUSH_EN
    bus.flush    = fl;
`else
    if (fl) $display("[TB] note: flush ignored in this build");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  logic [31:0] exp_words [4];

  initial begin
    rst          = 1'b0;
    bus.din      = 8'h00;
    bus.din_v    = 1'b0;
    bus.dout_rdy = 1'b0;
`ifdef PACK_FLUSH_EN
    bus.flush    = 1'b0;
`endif
    #2;
    doReset();
    checkOutput("reset_dout_v", 32'(bus.dout_v), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_dout", bus.dout, 32'h0);
    checkOutput("reset_dout_bytes", 32'(bus.dout_bytes), 32'd0);

    // Basic word assembly and same-edge latency
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b0);
    checkOutput("three_bytes_no_word", 32'(bus.dout_v), 32'd0);
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
    checkOutput("first_word_dout", bus.dout, 32'h44332211);
    checkOutput("first_word_bytes", 32'(bus.dout_bytes), 32'd4);
    checkOutput("first_word_v", 32'(bus.dout_v), 32'd1);
    checkOutput("first_word_level", 32'(level), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(8'hEE, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_hold_level", 32'(level), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("pop_level", 32'(level), 32'd0);
    checkOutput("pop_dout_zero", bus.dout, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("no_underflow", 32'(level), 32'd0);
    // The idle cycles must not have disturbed the byte counter
    applyStimulus(8'hA1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hA2, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hA3, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hA4, 1'b1, 1'b0, 1'b0);
    checkOutput("aligned_after_idle", bus.dout, 32'hA4A3A2A1);

    // Overflow: 20 bytes into a 4-deep FIFO with no consumer
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i == 15) begin
        checkOutput("full_level", 32'(level), 32'd4);
        checkOutput("full_no_ovf", 32'(ovf), 32'd0);
      end
    end
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    exp_words = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_word%0d", i), bus.dout, exp_words[i]);
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);

    // Simultaneous push and pop while full
    doReset();
    for (int i = 0; i < 19; i++) applyStimulus(8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h53, 1'b1, 1'b1, 1'b0);
    checkOutput("pushpop_level", 32'(level), 32'd4);
    checkOutput("pushpop_ovf", 32'(ovf), 32'd0);
    exp_words = '{32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C, 32'h53525150};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pushpop_word%0d", i), bus.dout, exp_words[i]);
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    end

    // Reset mid-word discards the partial bytes
    doReset();
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b0);
    doReset();
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_no_early_word", 32'(level), 32'd0);
    applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_word", bus.dout, 32'h04030201);
    checkOutput("post_reset_level", 32'(level), 32'd1);
    checkOutput("post_reset_ovf", 32'(ovf), 32'd0);

    // Reset wins over a same-edge byte and ready with the FIFO occupied
    rst = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("rst_priority_level", 32'(level), 32'd0);
    applyStimulus(8'h61, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h63, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_priority_byte_dropped", 32'(level), 32'd0);
    applyStimulus(8'h64, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_priority_word", bus.dout, 32'h64636261);

`ifdef PACK_FLUSH_EN
    doReset();
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_partial_dout", bus.dout, 32'h0000BBAA);
    checkOutput("flush_partial_bytes", 32'(bus.dout_bytes), 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    checkOutput("flush_then_full_level", 32'(level), 32'd2);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_then_full_word", bus.dout, 32'hC3C2C1C0);
    checkOutput("flush_then_full_bytes", 32'(bus.dout_bytes), 32'd4);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_empty_noop", 32'(level), 32'd0);
    applyStimulus(8'hD0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hD1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hD2, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hD3, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_with_4th_level", 32'(level), 32'd1);
    checkOutput("flush_with_4th_word", bus.dout, 32'hD3D2D1D0);
    applyStimulus(8'hE0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hE1, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_same_edge_level", 32'(level), 32'd2);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_same_edge_word", bus.dout, 32'h0000E1E0);
    checkOutput("flush_same_edge_bytes", 32'(bus.dout_bytes), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
